// File: rtl/hdmi_pattern_sequencer.sv
// Frame-synchronous display-mode sequencer for the HDMI test-pattern generator.
// Mode changes (auto dwell, next/prev/load) are applied only at vertical-sync frame start.
module hdmi_pattern_sequencer #(
  parameter int NUM_MODES     = 11,
  parameter int DWELL_FRAMES  = 60,
  parameter int VS_ACTIVE_LOW = 1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vs_in,
  input  logic        auto_en,
  input  logic        hold,
  input  logic        next_req,
  input  logic        prev_req,
  input  logic        load_req,
  input  logic [3:0]  load_mode,
  output logic [3:0]  dis_mode,
  output logic        mode_changed,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic [7:0]  dwell_cnt
);

  localparam logic [3:0] LAST_MODE  = 4'(NUM_MODES - 1);
  localparam logic [7:0] DWELL_LAST = 8'(DWELL_FRAMES - 1);
  localparam logic       VS_IDLE    = (VS_ACTIVE_LOW != 0);

  typedef enum logic {RUN, MANUAL} state_t;

  state_t      state, state_nxt;
  logic        vs_d, fs_det, load_ok;
  logic        next_pend, prev_pend, load_pend;
  logic [3:0]  load_val;
  logic        ap_next, ap_prev, ap_load;
  logic [3:0]  ap_val;
  logic [3:0]  mode_nxt, mode_inc, mode_dec;
  logic [7:0]  dwell_nxt;
  logic        changed;

  assign fs_det   = VS_IDLE ? (vs_d & ~vs_in) : (~vs_d & vs_in);
  assign load_ok  = load_req && ({1'b0, load_mode} < 5'(NUM_MODES));
  assign mode_inc = (dis_mode == LAST_MODE) ? 4'd0 : dis_mode + 4'd1;
  assign mode_dec = (dis_mode == 4'd0) ? LAST_MODE : dis_mode - 4'd1;

  // Vertical-sync edge detection, registered into the frame_start pulse
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_d        <= VS_IDLE;
      frame_start <= 1'b0;
    end else begin
      vs_d        <= vs_in;
      frame_start <= fs_det;
    end
  end

  // Pending requests; snapshotted at the detect edge so a request arriving
  // on that same edge is deferred to the following frame
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      next_pend <= 1'b0;
      prev_pend <= 1'b0;
      load_pend <= 1'b0;
      load_val  <= 4'd0;
      ap_next   <= 1'b0;
      ap_prev   <= 1'b0;
      ap_load   <= 1'b0;
      ap_val    <= 4'd0;
    end else begin
      if (fs_det) begin
        ap_next   <= next_pend;
        ap_prev   <= prev_pend;
        ap_load   <= load_pend;
        ap_val    <= load_val;
        next_pend <= next_req;
        prev_pend <= prev_req;
        load_pend <= load_ok;
      end else begin
        next_pend <= next_pend | next_req;
        prev_pend <= prev_pend | prev_req;
        load_pend <= load_pend | load_ok;
      end
      if (load_ok) begin
        load_val <= load_mode;
      end
    end
  end

  // Next-state, mode resolution and dwell bookkeeping at each frame start
  always_comb begin
    state_nxt = state;
    mode_nxt  = dis_mode;
    dwell_nxt = dwell_cnt;
    changed   = 1'b0;
    if (frame_start) begin
      state_nxt = auto_en ? RUN : MANUAL;
      if (ap_load) begin
        mode_nxt = ap_val;
        changed  = 1'b1;
      end else if (ap_next && ap_prev) begin
        changed = 1'b0;
      end else if (ap_next) begin
        mode_nxt = mode_inc;
        changed  = 1'b1;
      end else if (ap_prev) begin
        mode_nxt = mode_dec;
        changed  = 1'b1;
      end else begin
        case (state_nxt)
          RUN: begin
            if (!hold && dwell_cnt == DWELL_LAST) begin
              mode_nxt = mode_inc;
              changed  = 1'b1;
            end else if (!hold && dwell_cnt != 8'hFF) begin
              dwell_nxt = dwell_cnt + 8'd1;
            end else begin
              dwell_nxt = dwell_cnt;
            end
          end
          MANUAL:  dwell_nxt = dwell_cnt;
          default: dwell_nxt = dwell_cnt;
        endcase
      end
      if (changed) begin
        dwell_nxt = 8'd0;
      end else begin
        dwell_nxt = dwell_nxt;
      end
    end else begin
      state_nxt = state;
    end
  end

  // State and output registers
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      dis_mode     <= 4'd0;
      dwell_cnt    <= 8'd0;
      frame_cnt    <= 16'd0;
      mode_changed <= 1'b0;
    end else begin
      state        <= state_nxt;
      dis_mode     <= mode_nxt;
      dwell_cnt    <= dwell_nxt;
      mode_changed <= changed;
      if (frame_start) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_pattern_sequencer.sv
// Directed bench for hdmi_pattern_sequencer with NUM_MODES=11, DWELL_FRAMES=3, active-low VS.
module tb_hdmi_pattern_sequencer;

  logic        pclk = 1'b0;
  logic        rst, vs_in, auto_en, hold, next_req, prev_req, load_req;
  logic [3:0]  load_mode;
  logic [3:0]  dis_mode;
  logic        mode_changed, frame_start;
  logic [15:0] frame_cnt;
  logic [7:0]  dwell_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int fs_count = 0;
  int mc_count = 0;
  int mc_base;
  int fs_base;

  hdmi_pattern_sequencer #(.NUM_MODES(11), .DWELL_FRAMES(3), .VS_ACTIVE_LOW(1)) dut (
    .pclk(pclk), .rst(rst), .vs_in(vs_in), .auto_en(auto_en), .hold(hold),
    .next_req(next_req), .prev_req(prev_req), .load_req(load_req), .load_mode(load_mode),
    .dis_mode(dis_mode), .mode_changed(mode_changed), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .dwell_cnt(dwell_cnt)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (frame_start) fs_count <= fs_count + 1;
    if (mode_changed) mc_count <= mc_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic vs_pulse();
    @(negedge pclk) vs_in = 1'b0;
    repeat (2) @(negedge pclk);
    vs_in = 1'b1;
    repeat (4) @(negedge pclk);
  endtask

  task automatic request(input logic nx, input logic pv, input logic ld, input logic [3:0] val);
    @(negedge pclk);
    next_req = nx; prev_req = pv; load_req = ld; load_mode = val;
    @(negedge pclk);
    next_req = 1'b0; prev_req = 1'b0; load_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vs_in = 1'b1; auto_en = 1'b1; hold = 1'b0;
    next_req = 1'b0; prev_req = 1'b0; load_req = 1'b0; load_mode = 4'd0;
    repeat (3) @(negedge pclk);
    check("rst_mode", 32'(dis_mode), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    check("rst_dwell", 32'(dwell_cnt), 32'd0);
    check("rst_mc", 32'(mode_changed), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge pclk);

    // Auto run: mode steps every 3 frames
    for (int k = 1; k <= 10; k++) begin
      vs_pulse();
      check($sformatf("auto_mode_%0d", k), 32'(dis_mode), 32'(k / 3));
    end
    check("auto_mc_count", 32'(mc_count), 32'd3);
    check("auto_fs_count", 32'(fs_count), 32'd10);
    check("auto_fcnt", 32'(frame_cnt), 32'd10);
    check("auto_dwell", 32'(dwell_cnt), 32'd1);

    // Manual: dwell frozen, load and wrap
    auto_en = 1'b0;
    vs_pulse();
    check("man_mode", 32'(dis_mode), 32'd3);
    check("man_dwell", 32'(dwell_cnt), 32'd1);
    request(1'b0, 1'b0, 1'b1, 4'd10); vs_pulse();
    check("load10", 32'(dis_mode), 32'd10);
    check("load_dwell0", 32'(dwell_cnt), 32'd0);
    request(1'b1, 1'b0, 1'b0, 4'd0); vs_pulse();
    check("wrap_up", 32'(dis_mode), 32'd0);
    request(1'b0, 1'b1, 1'b0, 4'd0); vs_pulse();
    check("wrap_down", 32'(dis_mode), 32'd10);

    // Priority
    request(1'b1, 1'b0, 1'b1, 4'd7); vs_pulse();
    check("load_over_next", 32'(dis_mode), 32'd7);
    mc_base = mc_count;
    request(1'b1, 1'b1, 1'b0, 4'd0); vs_pulse();
    check("cancel_mode", 32'(dis_mode), 32'd7);
    check("cancel_no_mc", 32'(mc_count), 32'(mc_base));
    vs_pulse();
    check("cancel_cleared", 32'(dis_mode), 32'd7);
    request(1'b0, 1'b0, 1'b1, 4'd12); vs_pulse();
    check("load12_ignored", 32'(dis_mode), 32'd7);
    check("load12_no_mc", 32'(mc_count), 32'(mc_base));
    request(1'b0, 1'b0, 1'b1, 4'd7); vs_pulse();
    check("load_same_mc", 32'(mc_count), 32'(mc_base + 1));

    // Request coincident with the frame-start detect edge is deferred
    @(negedge pclk) vs_in = 1'b0; next_req = 1'b1;
    @(negedge pclk) next_req = 1'b0;
    @(negedge pclk) vs_in = 1'b1;
    repeat (4) @(negedge pclk);
    check("coinc_deferred", 32'(dis_mode), 32'd7);
    vs_pulse();
    check("coinc_applied", 32'(dis_mode), 32'd8);

    // Hold freezes dwell and auto advance; manual next still works
    auto_en = 1'b1;
    vs_pulse();
    check("run_dwell1", 32'(dwell_cnt), 32'd1);
    hold = 1'b1;
    repeat (5) vs_pulse();
    check("hold_dwell", 32'(dwell_cnt), 32'd1);
    check("hold_mode", 32'(dis_mode), 32'd8);
    request(1'b1, 1'b0, 1'b0, 4'd0); vs_pulse();
    check("hold_next", 32'(dis_mode), 32'd9);
    check("hold_next_dwell", 32'(dwell_cnt), 32'd0);
    check("fcnt_28", 32'(frame_cnt), 32'd28);
    hold = 1'b0;

    // Asynchronous reset mid-frame with mode 5 and a pending request
    request(1'b0, 1'b0, 1'b1, 4'd5); vs_pulse();
    check("pre_rst_mode", 32'(dis_mode), 32'd5);
    request(1'b1, 1'b0, 1'b0, 4'd0);
    #2 rst = 1'b1;
    #1;
    check("async_mode", 32'(dis_mode), 32'd0);
    check("async_fcnt", 32'(frame_cnt), 32'd0);
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    fs_base = fs_count;
    repeat (10) @(negedge pclk);
    check("no_spurious_fs", 32'(fs_count), 32'(fs_base));
    vs_pulse();
    check("post_rst_mode", 32'(dis_mode), 32'd0);
    check("post_rst_fcnt", 32'(frame_cnt), 32'd1);
    check("post_rst_dwell", 32'(dwell_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hdmi_pattern_sequencer.md
# hdmi_pattern_sequencer

Frame-synchronous controller for the HDMI 1280x720@60 test-pattern generator. It decides which display mode (0..NUM_MODES-1) the pattern datapath renders, advancing automatically after a programmable number of frames or on manual next/prev/load requests. All mode changes are applied only at frame start (leading edge of vertical sync), so a frame is never torn. It sits between the board controls or a register interface and the generator's mode-select input, fed back by the generator's own VS output.

## Interface
- NUM_MODES, 11, number of valid patterns; mode wraps at NUM_MODES-1 <-> 0
- DWELL_FRAMES, 60, frames per mode in auto mode (>=1)
- VS_ACTIVE_LOW, 1, 1: frame start = falling edge of vs_in; 0: rising edge
- pclk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- vs_in  in  1  vertical sync from the timing generator, pclk domain
- auto_en  in  1  level; 1 enables dwell-based auto advance
- hold  in  1  level; freezes the dwell counter; does not block manual requests
- next_req  in  1  pulse; request mode+1
- prev_req  in  1  pulse; request mode-1
- load_req  in  1  pulse; request mode = load_mode
- load_mode  in  4  target mode for load_req
- dis_mode  out  4  current display mode to the pattern datapath
- mode_changed  out  1  one-cycle pulse when dis_mode updates
- frame_start  out  1  one-cycle pulse per detected frame start
- frame_cnt  out  16  free-running frame counter, wraps 65535 -> 0
- dwell_cnt  out  8  frames elapsed in the current mode

## Operation
- Edge detect: vs_in registered into vs_d; frame start when (vs_d,vs_in) = (1,0) with VS_ACTIVE_LOW=1, (0,1) otherwise. Registered into frame_start.
- Pending register set: next_pend, prev_pend, load_pend + load_val, each set by its request pulse and held until a frame start consumes it. Repeated pulses before consumption: next/prev stay set (one step only); load_val takes the latest load_mode.
- load_mode >= NUM_MODES: load_req ignored, load_pend not set.
- States: RUN (auto_en=1) and MANUAL (auto_en=0); state follows auto_en, sampled on each frame_start.
- On frame_start, priority resolution:
  - load_pend: dis_mode = load_val.
  - else next_pend and prev_pend both set: cancel each other, no change, both cleared.
  - else next_pend: dis_mode+1, wrap NUM_MODES-1 -> 0.
  - else prev_pend: dis_mode-1, wrap 0 -> NUM_MODES-1.
  - else RUN, hold=0, dwell_cnt = DWELL_FRAMES-1: advance as next.
  - else no change; dwell_cnt+1 if hold=0, unless in MANUAL (saturates at 255).
- All pending bits cleared on every frame_start, whether or not they changed the mode.
- On any mode change: dwell_cnt = 0 and mode_changed pulses. A load to the current value counts as a change (pulse, dwell reset).
- frame_cnt increments on every frame_start regardless of state.

## Timing
- Reset: dis_mode=0, mode_changed=0, frame_start=0, frame_cnt=0, dwell_cnt=0, all pending cleared, vs_d=1 if VS_ACTIVE_LOW else 0, state RUN if auto_en.
- Latency: vs_in edge sampled at clock edge N; frame_start high N..N+1. dis_mode, dwell_cnt, frame_cnt update at N+1; mode_changed high N+1..N+2.
- A request sampled at the same edge that raises frame_start is not applied at that frame; it remains pending for the next frame start. Pending set at any earlier edge is applied.
- A request sampled at edge N+1 (the consuming edge) survives: set wins over clear.
- Reset asserted mid-frame: all outputs return to reset values immediately; after release, no frame_start until a genuine vs_in edge.

## Test plan
- Auto run, DWELL_FRAMES=3, 10 VS pulses: dis_mode 0,0,0,1,1,1,2,2,2,3. One mode_changed pulse per step. frame_cnt = 10.
- Wrap: NUM_MODES=11 at mode 10, next_req -> 0 at next frame start; from 0, prev_req -> 10.
- Priority: next_req and load_req(7) in the same frame -> dis_mode=7. next_req and prev_req in the same frame -> unchanged, no mode_changed, both pending clear.
- Boundary: next_req coincident with frame_start -> applied one frame later. load_req(12) -> ignored.
- hold=1 with auto_en=1 for 5 frames -> dwell_cnt frozen, no auto advance, while next_req still advances the mode.
- Assert rst mid-frame with mode=5 and pending set -> dis_mode=0, frame_cnt=0 asynchronously. The first frame_start occurs only after a real VS edge.
